// File: rtl/image_serializer.sv
// Row-serial image transmitter: shadows a 196-bit image on start and emits it as 28 words of 7 bits under frame_n.
// Latency: word 0 is on data_out the cycle after the accepting edge; done pulses the cycle after the last word.
// Backpressure: none downstream; start is only taken while ready=1 and is dropped otherwise. IMAGE_SERIALIZER_CHECKSUM_EN appends an XOR word.
module image_serializer #(
    parameter int WORD_W     = 7,
    parameter int NUM_WORDS  = 28,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_W*NUM_WORDS-1:0] image_data,
    input  logic                        start,
    output logic                        ready,
    output logic                        frame_n,
    output logic [WORD_W-1:0]           data_out,
    output logic                        busy,
    output logic                        done
);
    localparam int IMG_W = WORD_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    logic [IMG_W-1:0]   shadow;
    logic [CNT_W-1:0]   word_cnt;
    logic [3:0]         gap_cnt;
    logic               last_beat;

`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
    logic [WORD_W-1:0]  csum;
    logic               csum_sent;

    assign last_beat = (word_cnt == LAST_WORD) && csum_sent;
`else
    assign last_beat = (word_cnt == LAST_WORD);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shadow   <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
            ready    <= 1'b1;
            frame_n  <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
            csum      <= '0;
            csum_sent <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Word 0 goes straight out; the shadow keeps the rest, pre-shifted.
                        state    <= SEND;
                        shadow   <= image_data >> WORD_W;
                        data_out <= image_data[WORD_W-1:0];
                        word_cnt <= '0;
                        frame_n  <= 1'b1;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
                        csum      <= image_data[WORD_W-1:0];
                        csum_sent <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (last_beat) begin
                        frame_n  <= 1'b0;
                        data_out <= '0;
                        done     <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
                    end else if (word_cnt == LAST_WORD) begin
                        data_out  <= csum;
                        csum_sent <= 1'b1;
`endif
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        data_out <= shadow[WORD_W-1:0];
                        shadow   <= shadow >> WORD_W;
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
                        csum     <= csum ^ shadow[WORD_W-1:0];
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_serializer.sv
// Scoreboard bench for image_serializer: one instance with a 2-cycle gap, one with no gap for back-to-back loopback.
module tb_image_serializer;
    localparam int WORD_W    = 7;
    localparam int NUM_WORDS = 28;
    localparam int IMG_W     = WORD_W * NUM_WORDS;
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_WORDS + 1;
`else
    localparam int FRAME_LEN = NUM_WORDS;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [IMG_W-1:0]  image_data, image0;
    logic              start, start0;
    logic              ready, frame_n, busy, done;
    logic              ready0, frame_n0, busy0, done0;
    logic [WORD_W-1:0] data_out, data_out0;

    logic [WORD_W-1:0] exp_q[$];
    logic [IMG_W-1:0]  img_q[$];
    int vectors = 0;
    int errors  = 0;

    image_serializer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .image_data(image_data), .start(start),
        .ready(ready), .frame_n(frame_n), .data_out(data_out), .busy(busy), .done(done)
    );

    image_serializer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .image_data(image0), .start(start0),
        .ready(ready0), .frame_n(frame_n0), .data_out(data_out0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IMG_W-1:0] ramp_img();
        logic [IMG_W-1:0] img;
        for (int k = 0; k < NUM_WORDS; k++) img[WORD_W*k +: WORD_W] = WORD_W'(k);
        return img;
    endfunction

    function automatic logic [IMG_W-1:0] rand_img();
        logic [IMG_W-1:0] img;
        for (int k = 0; k < NUM_WORDS; k++) img[WORD_W*k +: WORD_W] = WORD_W'($urandom);
        return img;
    endfunction

    function automatic logic [WORD_W-1:0] calc_csum(input logic [IMG_W-1:0] img);
        logic [WORD_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_WORDS; k++) c ^= img[WORD_W*k +: WORD_W];
        return c;
    endfunction

    task automatic push_words(input logic [IMG_W-1:0] img);
        for (int k = 0; k < NUM_WORDS; k++) exp_q.push_back(img[WORD_W*k +: WORD_W]);
`ifdef IMAGE_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(calc_csum(img));
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start0 = 1'b0;
        image_data = '0; image0 = '0;
        tick(); tick();
        vectors++;
        if ({ready, frame_n, busy, done} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl got %b want 1000", {ready, frame_n, busy, done});
        end
        vectors++;
        if (data_out !== '0 || data_out0 !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0", data_out, data_out0);
        end
        vectors++;
        if ({ready0, frame_n0, busy0, done0} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl0 got %b want 1000", {ready0, frame_n0, busy0, done0});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (ready !== 1'b1 || frame_n !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset ready=%b frame_n=%b want 1/0", ready, frame_n);
        end
    endtask

    // Sends one frame on u_dut and checks every word, the done pulse and the gap timing.
    task automatic run_frame(input logic [IMG_W-1:0] img, input bit overwrite, input bit poke, input string name);
        int n;
        int guard;
        logic [WORD_W-1:0] exp;
        guard = 0;
        while (ready !== 1'b1 && guard < 60) begin tick(); guard++; end
        vectors++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout got %b want 1", name, ready); end
        image_data = img; start = 1'b1;
        tick();
        start = 1'b0;
        push_words(img);
        if (overwrite) image_data = '1;
        n = 0;
        while (frame_n === 1'b1 && n < 40) begin
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL %s extra_word %0d got %h want none", name, n, data_out);
            end else begin
                exp = exp_q.pop_front();
                vectors++;
                if (data_out !== exp) begin
                    errors++; $display("FAIL %s word%0d got %h want %h", name, n, data_out, exp);
                end
            end
            vectors++;
            if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL %s send_ctrl%0d got r=%b b=%b d=%b want 0/1/0", name, n, ready, busy, done);
            end
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            tick(); n++;
        end
        vectors++;
        if (n !== FRAME_LEN) begin errors++; $display("FAIL %s frame_len got %0d want %0d", name, n, FRAME_LEN); end
        vectors++;
        if (done !== 1'b1 || data_out !== '0 || busy !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL %s done_cycle got d=%b data=%h b=%b r=%b want 1/0/1/0", name, done, data_out, busy, ready);
        end
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_words got %0d left want 0", name, exp_q.size()); end
        exp_q.delete();
        if (poke) start = 1'b1;
        tick();
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || frame_n !== 1'b0) begin
            errors++; $display("FAIL %s gap1 got r=%b b=%b d=%b f=%b want 0/1/0/0", name, ready, busy, done, frame_n);
        end
        tick();
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || frame_n !== 1'b0) begin
            errors++; $display("FAIL %s ready_return got r=%b b=%b f=%b want 1/0/0", name, ready, busy, frame_n);
        end
        start = 1'b0;
        tick();
        vectors++;
        if (frame_n !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL %s dropped_start got f=%b r=%b want 0/1", name, frame_n, ready);
        end
    endtask

    task automatic test_ramp();
        run_frame(ramp_img(), 1'b0, 1'b0, "ramp");
    endtask

    task automatic test_shadow();
        run_frame(ramp_img(), 1'b1, 1'b0, "shadow");
    endtask

    task automatic test_drop_start();
        run_frame(rand_img(), 1'b0, 1'b1, "drop_start");
    endtask

    task automatic test_reset_mid();
        logic [IMG_W-1:0] img;
        img = rand_img();
        image_data = img; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        vectors++;
        if (data_out !== img[WORD_W*10 +: WORD_W] || frame_n !== 1'b1) begin
            errors++; $display("FAIL mid_word10 got %h f=%b want %h f=1", data_out, frame_n, img[WORD_W*10 +: WORD_W]);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({ready, frame_n, busy, done} !== 4'b1000 || data_out !== '0) begin
            errors++; $display("FAIL mid_reset got r/f/b/d=%b data=%h want 1000/0", {ready, frame_n, busy, done}, data_out);
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b0 || frame_n !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL post_reset got d=%b f=%b r=%b want 0/0/1", done, frame_n, ready);
        end
        run_frame(ramp_img(), 1'b0, 1'b0, "after_reset");
    endtask

    // Held start on the zero-gap instance: loop the words back into an image and compare per frame.
    task automatic test_back_to_back();
        logic [IMG_W-1:0] imgs[4];
        logic [IMG_W-1:0] rx, exp_img;
        int n;
        int guard;
        imgs[0] = ramp_img();
        for (int i = 1; i < 4; i++) imgs[i] = rand_img();
        image0 = imgs[0]; start0 = 1'b1;
        tick();
        img_q.push_back(imgs[0]);
        for (int f = 0; f < 3; f++) begin
            image0 = imgs[f+1];
            rx = '0; n = 0;
            exp_img = (img_q.size() != 0) ? img_q[0] : '0;
            while (frame_n0 === 1'b1 && n < 40) begin
                if (n < NUM_WORDS) rx[WORD_W*n +: WORD_W] = data_out0;
                else begin
                    vectors++;
                    if (data_out0 !== calc_csum(exp_img)) begin
                        errors++; $display("FAIL b2b_csum%0d got %h want %h", f, data_out0, calc_csum(exp_img));
                    end
                end
                tick(); n++;
            end
            vectors++;
            if (n !== FRAME_LEN) begin errors++; $display("FAIL b2b_len%0d got %0d want %0d", f, n, FRAME_LEN); end
            vectors++;
            if (done0 !== 1'b1 || data_out0 !== '0 || ready0 !== 1'b1) begin
                errors++; $display("FAIL b2b_done%0d got d=%b data=%h r=%b want 1/0/1", f, done0, data_out0, ready0);
            end
            if (img_q.size() == 0) begin
                errors++; $display("FAIL b2b_underflow%0d got empty want image", f);
            end else begin
                exp_img = img_q.pop_front();
                vectors++;
                if (rx !== exp_img) begin errors++; $display("FAIL b2b_image%0d got %h want %h", f, rx, exp_img); end
            end
            tick();
            vectors++;
            if (frame_n0 !== 1'b1 || done0 !== 1'b0) begin
                errors++; $display("FAIL b2b_gap%0d got f=%b d=%b want 1/0", f, frame_n0, done0);
            end
            img_q.push_back(imgs[f+1]);
        end
        start0 = 1'b0;
        guard = 0;
        while (ready0 !== 1'b1 && guard < 80) begin tick(); guard++; end
        vectors++;
        if (ready0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got r=%b b=%b want 1/0", ready0, busy0);
        end
        img_q.delete();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_shadow();
        test_drop_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
